// File: rtl/divider_if.sv
// Start/done handshake bundle between a requester and restoring_divider_ctrl.
// The abort request exists only when DIVIDER_ABORT_EN is defined.
interface divider_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
`ifdef DIVIDER_ABORT_EN
    logic         abort;
`endif

    modport master (
`ifdef DIVIDER_ABORT_EN
        output abort,
`endif
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
`ifdef DIVIDER_ABORT_EN
        input  abort,
`endif
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/restoring_divider_ctrl.sv
// Sequential unsigned restoring divider: one ripple-borrow trial subtraction per cycle.
// Optional feature macro: DIVIDER_ABORT_EN adds an abort request that cancels a running division.
module restoring_divider_ctrl #(
    parameter int unsigned N = 8
) (
    input logic      clk,
    input logic      rst_n,
    divider_if.slave bus
);
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state;
    logic [N-1:0] q_sr;
    logic [N-1:0] d_reg;
    logic [N:0]   r_reg;
    logic [CW-1:0] count;
    logic         busy_r;
    logic         done_r;
    logic         dbz_r;
    logic [N-1:0] quo_r;
    logic [N-1:0] rem_r;

    logic [N:0]   trial;
    logic [N:0]   diff;
    logic         borrow;
    logic [N:0]   r_next;
    logic [N-1:0] q_next;

    // (N+1)-bit ripple chain of full subtractors; returns {borrow_out, difference}.
    function automatic logic [N+1:0] ripple_sub(input logic [N:0] a, input logic [N:0] b);
        logic [N:0] d;
        logic       bw;
        bw = 1'b0;
        for (int unsigned i = 0; i < N + 1; i++) begin
            d[i] = a[i] ^ b[i] ^ bw;
            bw   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw);
        end
        return {bw, d};
    endfunction

    // One restoring iteration: a borrow means the divisor did not fit, so keep T.
    always_comb begin
        trial          = {r_reg[N-1:0], q_sr[N-1]};
        {borrow, diff} = ripple_sub(trial, {1'b0, d_reg});
        r_next         = borrow ? trial : diff;
        q_next         = {q_sr[N-2:0], ~borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            q_sr   <= '0;
            d_reg  <= '0;
            r_reg  <= '0;
            count  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            quo_r  <= '0;
            rem_r  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            quo_r  <= '1;
                            rem_r  <= bus.dividend;
                            dbz_r  <= 1'b1;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            q_sr   <= bus.dividend;
                            d_reg  <= bus.divisor;
                            r_reg  <= '0;
                            count  <= '0;
                            busy_r <= 1'b1;
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
`ifdef DIVIDER_ABORT_EN
                    if (bus.abort) begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end else
`endif
                    begin
                        q_sr  <= q_next;
                        r_reg <= r_next;
                        count <= count + CW'(1);
                        if (count == CW'(N - 1)) begin
                            quo_r  <= q_next;
                            rem_r  <= r_next[N-1:0];
                            dbz_r  <= 1'b0;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.quotient    = quo_r;
    assign bus.remainder   = rem_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// Directed plus randomized bench for restoring_divider_ctrl (N=8) against an arithmetic reference.
// Abort scenarios are exercised only when DIVIDER_ABORT_EN is defined.
module tb_restoring_divider_ctrl;
    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    divider_if #(.N(N)) bus ();

    restoring_divider_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; divide-by-zero yields all ones and the dividend.
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [N-1:0] q, output logic [N-1:0] r, output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge after the done cycle.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
        logic [N-1:0] eq, er;
        logic ez;
        int   cyc, busy_cyc;
        bit   seen, overlap;
        model(a, b, eq, er, ez);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = N'($urandom);
        bus.divisor  = N'($urandom);
`ifdef DIVIDER_ABORT_EN
        bus.abort    = 1'b0;
`endif
        cyc = 0; busy_cyc = 0; seen = 0; overlap = 0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.busy) busy_cyc++;
            if (bus.busy && bus.done) overlap = 1;
            if (bus.done) seen = 1;
        end
        check({tag, ".done_seen"}, 32'(seen), 32'(1));
        check({tag, ".latency"}, 32'(cyc), (b == 0) ? 32'(1) : 32'(N + 1));
        check({tag, ".busy_cycles"}, 32'(busy_cyc), (b == 0) ? 32'(0) : 32'(N));
        check({tag, ".overlap"}, 32'(overlap), 32'(0));
        check({tag, ".quotient"}, 32'(bus.quotient), 32'(eq));
        check({tag, ".remainder"}, 32'(bus.remainder), 32'(er));
        check({tag, ".div_by_zero"}, 32'(bus.div_by_zero), 32'(ez));
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(bus.done), 32'(0));
    endtask

    initial begin : stim
        int   ndone, last_t;
        bit   stray_done;
        logic [N-1:0] ra, rb;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef DIVIDER_ABORT_EN
        bus.abort    = 1'b0;
`endif
        #2;
        check("reset.outputs", 32'({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'd100, 8'd7, "basic_100_7");
        do_op(8'd255, 8'd1, "b2b_255_1");
        do_op(8'd5, 8'd9, "b2b_5_9");
        do_op(8'd37, 8'd0, "dbz_37_0");
        do_op(8'd200, 8'd10, "after_dbz_200_10");

        // Start held high: one result every N+2 cycles, dividend scrambled while busy.
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        ndone = 0; last_t = 0;
        for (int t = 1; t <= 40; t++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                check("held.quotient", 32'(bus.quotient), 32'(14));
                check("held.remainder", 32'(bus.remainder), 32'(2));
                check("held.gap", 32'(t - last_t), (ndone == 1) ? 32'(N + 1) : 32'(N + 2));
                last_t = t;
            end
            bus.dividend = bus.busy ? N'($urandom) : 8'd100;
        end
        bus.start = 1'b0; bus.dividend = 8'd100;
        check("held.count", 32'(ndone), 32'(4));

        // Asynchronous reset during iteration 4 of 200/3.
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd3;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.outputs", 32'({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}), 32'(0));
        stray_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) stray_done = 1;
        end
        check("midreset.no_done", 32'(stray_done), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'd200, 8'd3, "post_reset_200_3");

`ifdef DIVIDER_ABORT_EN
        do_op(8'd100, 8'd7, "pre_abort_100_7");
        bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd4;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        stray_done = 0;
        repeat (N + 2) begin
            @(negedge clk);
            if (bus.done || bus.busy) stray_done = 1;
        end
        check("abort.idle_no_done", 32'(stray_done), 32'(0));
        check("abort.quotient_kept", 32'(bus.quotient), 32'(14));
        check("abort.remainder_kept", 32'(bus.remainder), 32'(2));
        check("abort.dbz_kept", 32'(bus.div_by_zero), 32'(0));
        bus.abort = 1'b1;
        do_op(8'd50, 8'd4, "abort_with_start_50_4");
`endif

        // Randomized operands, including periodic zero divisors.
        for (int i = 0; i < 24; i++) begin
            ra = N'($urandom);
            rb = (i % 6 == 5) ? 8'd0 : N'($urandom_range(1, 255));
            do_op(ra, rb, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
